// File: rtl/fc_quant_pkg.sv
// Shared types and constants for the FC-layer requantizer scheduler.
package fc_quant_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic FC1_STATE = 1'b0;
    localparam logic FC2_STATE = 1'b1;
    localparam int   LANES     = 4;
    localparam int   BYTE_W    = 8;

endpackage

// File: rtl/fc_byte_packer.sv
// Packs requantized bytes four-per-word and issues registered SRAM word writes.
module fc_byte_packer
    import fc_quant_pkg::*;
#(
    parameter int CNT_W  = 9,
    parameter int ADDR_W = 10
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic                      clear,
    input  logic                      vld_p1,
    input  logic [BYTE_W-1:0]         q_byte,
    input  logic [CNT_W-1:0]          n_total,
    input  logic [ADDR_W-1:0]         base,
    output logic                      sram_wen,
    output logic [ADDR_W-1:0]         sram_addr,
    output logic [LANES*BYTE_W-1:0]   sram_wdata,
    output logic [LANES-1:0]          sram_bytemask,
    output logic                      wr_last
);

    logic [CNT_W-1:0]        out_cnt;
    logic [1:0]              lane;
    logic                    last;
    logic                    flush;
    logic [LANES*BYTE_W-1:0] pack_q;
    logic [LANES*BYTE_W-1:0] pack_next;
    logic [LANES-1:0]        lane_mask;
    logic [ADDR_W-1:0]       word_addr;

    assign lane      = out_cnt[1:0];
    assign last      = (out_cnt == n_total - CNT_W'(1));
    assign flush     = vld_p1 && ((lane == 2'd3) || last);
    assign word_addr = base + ADDR_W'(out_cnt >> 2);

    // Lanes at or below the current one are valid; only a short final word trims the mask.
    always_comb begin
        pack_next = pack_q;
        pack_next[int'(lane)*BYTE_W +: BYTE_W] = q_byte;
        lane_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_mask[i] = (i <= int'(lane));
        end
    end

    // Stage p2: byte lands in the pack register, full or final words go out.
    always_ff @(posedge clk) begin
        if (srst) begin
            out_cnt       <= '0;
            pack_q        <= '0;
            sram_wen      <= 1'b0;
            sram_addr     <= '0;
            sram_wdata    <= '0;
            sram_bytemask <= '0;
            wr_last       <= 1'b0;
        end else begin
            sram_wen <= flush;
            wr_last  <= flush && last;
            if (clear) begin
                out_cnt <= '0;
                pack_q  <= '0;
            end else if (vld_p1) begin
                out_cnt <= out_cnt + CNT_W'(1);
                if (flush) begin
                    pack_q        <= '0;
                    sram_wdata    <= pack_next;
                    sram_addr     <= word_addr;
                    sram_bytemask <= lane_mask;
                end else begin
                    pack_q <= pack_next;
                end
            end
        end
    end

endmodule

// File: rtl/fc_quant_scheduler.sv
// Sequences one FC layer's accumulator results through the shared requantizer into activation SRAM.
module fc_quant_scheduler
    import fc_quant_pkg::*;
#(
    parameter int FC1_OUT  = 500,
    parameter int FC2_OUT  = 10,
    parameter int ADDR_W   = 10,
    parameter int FC1_BASE = 0,
    parameter int FC2_BASE = 128
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              start,
    input  logic              layer_sel,
    input  logic              acc_valid,
    input  logic [31:0]       acc_data,
    output logic              acc_ready,
    output logic              q_fc_state,
    output logic [31:0]       q_unquant,
    input  logic [7:0]        q_quant,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    output logic [3:0]        sram_bytemask,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(FC1_OUT + 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  acc_cnt;
    logic [CNT_W-1:0]  n_q;
    logic [ADDR_W-1:0] base_q;
    logic              vld_p1;
    logic              start_ok;
    logic              accept;
    logic              last_accept;
    logic              wr_last;

    assign start_ok    = start && (state_q == IDLE);
    assign acc_ready   = (state_q == RUN) && (acc_cnt < n_q);
    assign accept      = acc_valid && acc_ready;
    assign last_accept = accept && (acc_cnt == n_q - CNT_W'(1));
    assign q_unquant   = acc_data;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)       state_d = RUN;
            RUN:     if (last_accept) state_d = DRAIN;
            DRAIN:   if (wr_last)     state_d = DONE;
            DONE:                     state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // Stage p0 -> p1: accept registers alongside the requantizer's own output register.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q    <= IDLE;
            acc_cnt    <= '0;
            n_q        <= '0;
            base_q     <= '0;
            q_fc_state <= FC1_STATE;
            vld_p1     <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_p1  <= accept;
            if (start_ok) begin
                q_fc_state <= layer_sel;
                n_q        <= (layer_sel == FC2_STATE) ? CNT_W'(FC2_OUT) : CNT_W'(FC1_OUT);
                base_q     <= (layer_sel == FC2_STATE) ? ADDR_W'(FC2_BASE) : ADDR_W'(FC1_BASE);
                acc_cnt    <= '0;
            end else if (accept) begin
                acc_cnt <= acc_cnt + CNT_W'(1);
            end
        end
    end

    fc_byte_packer #(
        .CNT_W  (CNT_W),
        .ADDR_W (ADDR_W)
    ) u_packer (
        .clk           (clk),
        .srst          (srst),
        .clear         (start_ok),
        .vld_p1        (vld_p1),
        .q_byte        (q_quant),
        .n_total       (n_q),
        .base          (base_q),
        .sram_wen      (sram_wen),
        .sram_addr     (sram_addr),
        .sram_wdata    (sram_wdata),
        .sram_bytemask (sram_bytemask),
        .wr_last       (wr_last)
    );

endmodule
